// File: rtl/eightbit_ctrl.sv
// eightbit_ctrl: fetch/decode/execute sequencer for the 8-bit accumulator machine.
// Define EIGHTBIT_ZFLAG_EN to add the zero flag and the JZ (0x06) opcode.
module eightbit_ctrl #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter bit         ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic [7:0] addr,
    output logic [7:0] data_out,
    output logic       we,
    output logic [7:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_en,
    input  logic [7:0] alu_y,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_MEMRD,
        S_MEMWR,
        S_EXEC,
        S_HALT
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] opr_q, opr_d;
    logic [7:0] addr_q, addr_d;
    logic       a_we;
    logic [7:0] a_nxt;
    logic       z_q;

`ifdef EIGHTBIT_ZFLAG_EN
    localparam bit ZEN = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
        end else if (a_we) begin
            z_q <= (a_nxt == 8'h00);
        end
    end
`else
    localparam bit ZEN = 1'b0;

    assign z_q = 1'b0;
`endif

    logic op_nop, op_ldai, op_ldb, op_ldam, op_sta;
    logic op_jmp, op_jz, op_alu, op_hlt;
    logic needs_opr, known, div0;

    assign op_nop    = (ir_q == 8'h00);
    assign op_ldai   = (ir_q == 8'h01);
    assign op_ldb    = (ir_q == 8'h02);
    assign op_ldam   = (ir_q == 8'h03);
    assign op_sta    = (ir_q == 8'h04);
    assign op_jmp    = (ir_q == 8'h05);
    assign op_jz     = ZEN && (ir_q == 8'h06);
    assign op_alu    = (ir_q[7:3] == 5'b00010);
    assign op_hlt    = (ir_q == 8'hFF);
    assign needs_opr = op_ldai | op_ldb | op_ldam | op_sta | op_jmp | op_jz;
    assign known     = needs_opr | op_alu | op_hlt | op_nop;
    assign div0      = (ir_q == 8'h13) && (b_q == 8'h00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        b_d     = b_q;
        opr_d   = opr_q;
        addr_d  = addr_q;
        a_we    = 1'b0;
        a_nxt   = a_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = data_in;
                pc_d    = pc_q + 8'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    needs_opr: begin
                        state_d = S_OPERAND;
                        addr_d  = pc_q;
                    end
                    op_alu:                  state_d = S_EXEC;
                    op_hlt:                  state_d = S_HALT;
                    (!known && ILLEGAL_HALT): state_d = S_HALT;
                    default: begin
                        state_d = S_FETCH;
                        addr_d  = pc_q;
                    end
                endcase
            end
            S_OPERAND: begin
                opr_d   = data_in;
                pc_d    = pc_q + 8'd1;
                addr_d  = pc_q + 8'd1;
                state_d = S_FETCH;
                unique case (1'b1)
                    op_ldai: begin
                        a_we  = 1'b1;
                        a_nxt = data_in;
                    end
                    op_ldb:  b_d = data_in;
                    op_ldam: state_d = S_MEMRD;
                    op_sta:  state_d = S_MEMWR;
                    (op_jmp || (op_jz && z_q)): begin
                        pc_d   = data_in;
                        addr_d = data_in;
                    end
                    default: ;
                endcase
            end
            S_MEMRD: begin
                a_we    = 1'b1;
                a_nxt   = data_in;
                addr_d  = pc_q;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                addr_d  = pc_q;
                state_d = S_FETCH;
            end
            S_EXEC: begin
                a_we    = !div0;
                a_nxt   = alu_y;
                addr_d  = pc_q;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        a_d = a_we ? a_nxt : a_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            opr_q   <= 8'h00;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opr_q   <= opr_d;
            addr_q  <= addr_d;
        end
    end

    // Data accesses address through the operand latch; fetches use addr_q.
    assign addr     = (state_q == S_MEMRD || state_q == S_MEMWR) ? opr_q : addr_q;
    assign we       = (state_q == S_MEMWR);
    assign data_out = we ? a_q : 8'h00;
    assign alu_op   = (state_q == S_EXEC) ? ir_q : 8'h00;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_en   = (state_q == S_EXEC) && !div0;
    assign halted   = (state_q == S_HALT);
    assign illegal  = (state_q == S_DECODE) && !known;

endmodule
